// File: rtl/cnn_layer_accel_job_pkg.sv
// Shared types for the CNN layer accelerator job dispatcher.
package cnn_layer_accel_job_pkg;

  // Dispatcher sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    ACK   = 2'd3
  } job_state_e;

  // Completion status reported with done_valid.
  typedef enum logic {
    OK      = 1'b0,
    TIMEOUT = 1'b1
  } done_status_e;

  // Index width for n quads; a single quad still gets a 1-bit (always 0) index.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_rr_arb.sv
// Round-robin arbiter: first requester at or after the pointer wins.
module cnn_layer_accel_rr_arb
  import cnn_layer_accel_job_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req_i,
  input  logic [idx_w(N)-1:0]   ptr_i,
  output logic [N-1:0]          gnt_o,
  output logic [idx_w(N)-1:0]   idx_o,
  output logic                  any_o
);

  localparam int IW = idx_w(N);

  // Scan the requests starting at the pointer, wrapping modulo N.
  always_comb begin
    int unsigned cand;
    cand  = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = IW'(cand);
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnn_layer_accel_job_dispatch.sv
// Job dispatcher: starts masked quads, serialises their fetches, collects completions.
module cnn_layer_accel_job_dispatch
  import cnn_layer_accel_job_pkg::*;
#(
  parameter int NUM_QUADS       = 4,
  parameter int JOB_PARAM_WIDTH = 128,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                        clk_if,
  input  logic                        rst,
  input  logic                        desc_valid,
  output logic                        desc_ready,
  input  logic [JOB_PARAM_WIDTH-1:0]  desc_params,
  input  logic [NUM_QUADS-1:0]        desc_quad_mask,
  output logic [NUM_QUADS-1:0]        job_start,
  input  logic [NUM_QUADS-1:0]        job_accept,
  output logic [JOB_PARAM_WIDTH-1:0]  job_parameters,
  input  logic [NUM_QUADS-1:0]        job_fetch_request,
  output logic [NUM_QUADS-1:0]        job_fetch_ack,
  output logic [NUM_QUADS-1:0]        job_fetch_complete,
  output logic                        fetch_valid,
  output logic [idx_w(NUM_QUADS)-1:0] fetch_idx,
  input  logic                        fetch_done,
  input  logic [NUM_QUADS-1:0]        job_complete,
  output logic [NUM_QUADS-1:0]        job_complete_ack,
  output logic                        done_valid,
  output logic                        done_status,
  output logic                        busy
);

  localparam int IDX_W = idx_w(NUM_QUADS);
  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  job_state_e                 state_q, state_d;
  done_status_e               dstatus_q, dstatus_d;
  logic [JOB_PARAM_WIDTH-1:0] params_q, params_d;
  logic [NUM_QUADS-1:0]       mask_q, mask_d;
  logic [NUM_QUADS-1:0]       start_q, start_d;
  logic [NUM_QUADS-1:0]       acc_q, acc_d;
  logic [NUM_QUADS-1:0]       done_set_q, done_set_d;
  logic [NUM_QUADS-1:0]       fack_q, fack_d;
  logic [NUM_QUADS-1:0]       fcpl_q, fcpl_d;
  logic [NUM_QUADS-1:0]       cack_q, cack_d;
  logic [IDX_W-1:0]           ptr_q, ptr_d;
  logic [IDX_W-1:0]           fidx_q, fidx_d;
  logic                       fv_q, fv_d;
  logic                       dvalid_q, dvalid_d;
  logic                       ready_q, ready_d;
  logic                       busy_q, busy_d;
  logic [TMO_W-1:0]           cnt_q, cnt_d;

  logic [NUM_QUADS-1:0] eligible, arb_gnt, acc_new, done_new;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any, fdone, tmo_hit;

  // Quads that have already finished are never granted another fetch.
  assign eligible = job_fetch_request & mask_q & ~done_set_q;
  assign acc_new  = job_accept & start_q;
  assign done_new = job_complete & mask_q & ~done_set_q;
  assign fdone    = fetch_done & fv_q;
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);

  cnn_layer_accel_rr_arb #(.N(NUM_QUADS)) u_arb (
    .req_i (eligible),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    dstatus_d  = OK;
    params_d   = params_q;
    mask_d     = mask_q;
    start_d    = start_q;
    acc_d      = acc_q;
    done_set_d = done_set_q;
    fack_d     = '0;
    fcpl_d     = '0;
    cack_d     = '0;
    ptr_d      = ptr_q;
    fidx_d     = fidx_q;
    fv_d       = fv_q;
    dvalid_d   = 1'b0;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (desc_valid && ready_q) begin
          params_d   = desc_params;
          mask_d     = desc_quad_mask;
          acc_d      = '0;
          done_set_d = '0;
          if (desc_quad_mask == '0) begin
            dvalid_d = 1'b1;
          end else begin
            state_d = START;
            start_d = desc_quad_mask;
          end
        end
      end
      START, RUN: begin
        start_d    = start_q & ~job_accept;
        acc_d      = acc_q | acc_new;
        done_set_d = done_set_q | (job_complete & mask_q);
        if (fdone) begin
          fcpl_d = NUM_QUADS'(1) << fidx_q;
          fv_d   = 1'b0;
          ptr_d  = (int'(fidx_q) == NUM_QUADS - 1) ? '0 : fidx_q + 1'b1;
        end
        if (state_q == START) begin
          if (acc_d == mask_q) state_d = RUN;
        end else if (done_set_q == mask_q && !fv_q) begin
          state_d  = ACK;
          cack_d   = mask_q;
          dvalid_d = 1'b1;
        end else if (!fv_q && arb_any) begin
          fack_d = arb_gnt;
          fv_d   = 1'b1;
          fidx_d = arb_idx;
        end
        // Any forward progress restarts the idle-handshake window.
        if (acc_new != '0 || fdone || done_new != '0) cnt_d = '0;
        else if (cnt_q != {TMO_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        if (tmo_hit) begin
          state_d   = IDLE;
          start_d   = '0;
          params_d  = '0;
          fack_d    = '0;
          fcpl_d    = '0;
          cack_d    = '0;
          fv_d      = 1'b0;
          dvalid_d  = 1'b1;
          dstatus_d = TIMEOUT;
          cnt_d     = '0;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers; reset abandons any job in flight.
  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dstatus_q  <= OK;
      params_q   <= '0;
      mask_q     <= '0;
      start_q    <= '0;
      acc_q      <= '0;
      done_set_q <= '0;
      fack_q     <= '0;
      fcpl_q     <= '0;
      cack_q     <= '0;
      ptr_q      <= '0;
      fidx_q     <= '0;
      fv_q       <= 1'b0;
      dvalid_q   <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      dstatus_q  <= dstatus_d;
      params_q   <= params_d;
      mask_q     <= mask_d;
      start_q    <= start_d;
      acc_q      <= acc_d;
      done_set_q <= done_set_d;
      fack_q     <= fack_d;
      fcpl_q     <= fcpl_d;
      cack_q     <= cack_d;
      ptr_q      <= ptr_d;
      fidx_q     <= fidx_d;
      fv_q       <= fv_d;
      dvalid_q   <= dvalid_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign desc_ready         = ready_q;
  assign job_start          = start_q;
  assign job_parameters     = params_q;
  assign job_fetch_ack      = fack_q;
  assign job_fetch_complete = fcpl_q;
  assign fetch_valid        = fv_q;
  assign fetch_idx          = fidx_q;
  assign job_complete_ack   = cack_q;
  assign done_valid         = dvalid_q;
  assign done_status        = dstatus_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_cnn_layer_accel_job_dispatch.sv
// Directed self-checking bench for the job dispatcher (4 quads, 16-cycle timeout).
module tb_cnn_layer_accel_job_dispatch;

  localparam int NQ = 4;
  localparam int PW = 32;

  logic          clk_if, rst;
  logic          desc_valid, desc_ready;
  logic [PW-1:0] desc_params, job_parameters;
  logic [NQ-1:0] desc_quad_mask, job_start, job_accept;
  logic [NQ-1:0] job_fetch_request, job_fetch_ack, job_fetch_complete;
  logic          fetch_valid, fetch_done;
  logic [1:0]    fetch_idx;
  logic [NQ-1:0] job_complete, job_complete_ack;
  logic          done_valid, done_status, busy;

  int checks = 0;
  int errors = 0;

  cnn_layer_accel_job_dispatch #(
    .NUM_QUADS(NQ), .JOB_PARAM_WIDTH(PW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_if(clk_if), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_params(desc_params), .desc_quad_mask(desc_quad_mask),
    .job_start(job_start), .job_accept(job_accept), .job_parameters(job_parameters),
    .job_fetch_request(job_fetch_request), .job_fetch_ack(job_fetch_ack),
    .job_fetch_complete(job_fetch_complete), .fetch_valid(fetch_valid),
    .fetch_idx(fetch_idx), .fetch_done(fetch_done),
    .job_complete(job_complete), .job_complete_ack(job_complete_ack),
    .done_valid(done_valid), .done_status(done_status), .busy(busy)
  );

  initial clk_if = 1'b0;
  always #5 clk_if = ~clk_if;

  task automatic step();
    @(posedge clk_if);
    #1;
  endtask

  // Offer a non-empty descriptor and check the START-cycle outputs.
  task automatic begin_job(input logic [NQ-1:0] m, input logic [PW-1:0] p);
    desc_valid = 1'b1; desc_quad_mask = m; desc_params = p;
    step();
    desc_valid = 1'b0; desc_quad_mask = '0; desc_params = '0;
    checks++; if (job_start !== m) begin errors++; $display("FAIL job_start_latch: got %b want %b", job_start, m); end
    checks++; if (job_parameters !== p) begin errors++; $display("FAIL job_params: got %h want %h", job_parameters, p); end
    checks++; if (desc_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL start_flags: ready=%b busy=%b want 0 1", desc_ready, busy); end
    $display("job start mask=%b params=%h", m, p);
  endtask

  // Report the remaining completions and check the ACK cycle and return to IDLE.
  task automatic complete_job(input logic [NQ-1:0] cpl, input logic [NQ-1:0] m);
    job_complete = cpl;
    step();
    job_complete = '0;
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL early_done: done_valid=%b want 0", done_valid); end
    step();
    checks++; if (job_complete_ack !== m) begin errors++; $display("FAIL complete_ack: got %b want %b", job_complete_ack, m); end
    checks++; if (done_valid !== 1'b1 || done_status !== 1'b0) begin errors++; $display("FAIL ack_done: valid=%b status=%b want 1 0", done_valid, done_status); end
    step();
    checks++; if (done_valid !== 1'b0 || job_complete_ack !== '0) begin errors++; $display("FAIL ack_pulse: valid=%b ack=%b want 0 0000", done_valid, job_complete_ack); end
    checks++; if (desc_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL back_idle: ready=%b busy=%b want 1 0", desc_ready, busy); end
    $display("job done mask=%b status=ok", m);
  endtask

  task automatic test_reset();
    step();
    checks++; if ({desc_ready, job_start, job_parameters, job_fetch_ack, job_fetch_complete, fetch_valid, fetch_idx,
                   job_complete_ack, done_valid, done_status, busy} !== '0) begin
      errors++; $display("FAIL reset_outputs: ready=%b start=%b fv=%b busy=%b want all 0", desc_ready, job_start, fetch_valid, busy);
    end
    rst = 1'b0;
    step();
    checks++; if (desc_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_release: ready=%b busy=%b want 1 0", desc_ready, busy); end
    $display("reset released");
  endtask

  task automatic test_round_robin();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    logic [NQ-1:0] e;
    begin_job(4'b1111, 32'hCAFE_0002);
    job_accept = 4'b1111; job_fetch_request = 4'b1111; fetch_done = 1'b1;
    step();
    job_accept = '0;
    step();
    fetch_done = 1'b0;
    checks++; if (job_fetch_complete !== '0) begin errors++; $display("FAIL stray_done: complete=%b want 0000", job_fetch_complete); end
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << exp_seq[k];
      checks++; if (job_fetch_ack !== e || fetch_valid !== 1'b1 || fetch_idx !== 2'(exp_seq[k])) begin
        errors++; $display("FAIL rr_grant%0d: ack=%b fv=%b idx=%0d want %b 1 %0d", k, job_fetch_ack, fetch_valid, fetch_idx, e, exp_seq[k]);
      end
      step();
      checks++; if (job_fetch_ack !== '0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL rr_hold%0d: ack=%b fv=%b want 0000 1", k, job_fetch_ack, fetch_valid); end
      fetch_done = 1'b1;
      if (k == 4) job_fetch_request = '0;
      step();
      fetch_done = 1'b0;
      checks++; if (job_fetch_complete !== e || fetch_valid !== 1'b0) begin
        errors++; $display("FAIL rr_complete%0d: complete=%b fv=%b want %b 0", k, job_fetch_complete, fetch_valid, e);
      end
      $display("fetch quad %0d complete", exp_seq[k]);
      step();
    end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rr_idle: fv=%b want 0", fetch_valid); end
    complete_job(4'b1111, 4'b1111);
  endtask

  task automatic test_complete_same_cycle();
    begin_job(4'b0011, 32'hCAFE_0003);
    job_accept = 4'b0011;
    step();
    job_accept = '0; job_fetch_request = 4'b0010;
    step();
    checks++; if (job_fetch_ack !== 4'b0010 || fetch_idx !== 2'd1) begin errors++; $display("FAIL sc_grant1: ack=%b idx=%0d want 0010 1", job_fetch_ack, fetch_idx); end
    fetch_done = 1'b1; job_complete = 4'b0010;
    step();
    fetch_done = 1'b0; job_complete = '0;
    checks++; if (job_fetch_complete !== 4'b0010 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL sc_complete1: complete=%b fv=%b want 0010 0", job_fetch_complete, fetch_valid);
    end
    $display("fetch quad 1 complete with job_complete");
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (job_fetch_ack !== '0 || fetch_valid !== 1'b0 || done_valid !== 1'b0) begin
        errors++; $display("FAIL sc_no_regrant%0d: ack=%b fv=%b done=%b want 0000 0 0", i, job_fetch_ack, fetch_valid, done_valid);
      end
    end
    job_fetch_request = 4'b0011;
    step();
    checks++; if (job_fetch_ack !== 4'b0001 || fetch_idx !== 2'd0) begin errors++; $display("FAIL sc_grant0: ack=%b idx=%0d want 0001 0", job_fetch_ack, fetch_idx); end
    fetch_done = 1'b1; job_fetch_request = 4'b0010;
    step();
    fetch_done = 1'b0;
    checks++; if (job_fetch_complete !== 4'b0001) begin errors++; $display("FAIL sc_complete0: complete=%b want 0001", job_fetch_complete); end
    complete_job(4'b0001, 4'b0011);
    job_fetch_request = '0;
  endtask

  task automatic test_start_accept();
    logic [NQ-1:0] es, ea;
    begin_job(4'b1011, 32'hCAFE_0001);
    for (int c = 0; c < 8; c++) begin
      es = {(c <= 4), 1'b0, (c <= 5), (c <= 3)};
      ea = (c == 7) ? 4'b0001 : 4'b0000;
      checks++; if (job_start !== es) begin errors++; $display("FAIL start_c%0d: job_start=%b want %b", c, job_start, es); end
      checks++; if (job_fetch_ack !== ea) begin errors++; $display("FAIL run_entry_c%0d: ack=%b want %b", c, job_fetch_ack, ea); end
      job_accept = ((c == 3) ? 4'b0001 : 4'b0000) | ((c == 5) ? 4'b0010 : 4'b0000) |
                   ((c == 4) ? 4'b1000 : 4'b0000) | ((c == 2) ? 4'b0100 : 4'b0000);
      job_fetch_request = 4'b0001;
      step();
    end
    job_accept = '0;
    checks++; if (fetch_valid !== 1'b1 || fetch_idx !== 2'd0) begin errors++; $display("FAIL sa_fetch: fv=%b idx=%0d want 1 0", fetch_valid, fetch_idx); end
    fetch_done = 1'b1; job_fetch_request = '0;
    step();
    fetch_done = 1'b0;
    checks++; if (job_fetch_complete !== 4'b0001) begin errors++; $display("FAIL sa_complete: complete=%b want 0001", job_fetch_complete); end
    complete_job(4'b1011, 4'b1011);
  endtask

  task automatic test_timeout();
    begin_job(4'b0001, 32'hCAFE_0004);
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c < 16) begin
        checks++; if (done_valid !== 1'b0 || job_start !== 4'b0001) begin
          errors++; $display("FAIL tmo_wait_c%0d: done=%b start=%b want 0 0001", c, done_valid, job_start);
        end
      end else begin
        checks++; if (done_valid !== 1'b1 || done_status !== 1'b1) begin errors++; $display("FAIL tmo_done: valid=%b status=%b want 1 1", done_valid, done_status); end
        checks++; if (job_start !== '0 || fetch_valid !== 1'b0 || job_parameters !== '0 || busy !== 1'b0) begin
          errors++; $display("FAIL tmo_clear: start=%b fv=%b params=%h busy=%b want 0", job_start, fetch_valid, job_parameters, busy);
        end
      end
    end
    $display("job timeout abort");
    step();
    checks++; if (desc_ready !== 1'b1 || done_valid !== 1'b0) begin errors++; $display("FAIL tmo_ready: ready=%b done=%b want 1 0", desc_ready, done_valid); end
  endtask

  task automatic test_zero_mask();
    desc_valid = 1'b1; desc_quad_mask = '0; desc_params = 32'h1234_5678;
    step();
    desc_valid = 1'b0; desc_params = '0;
    checks++; if (done_valid !== 1'b1 || done_status !== 1'b0) begin errors++; $display("FAIL zm_done: valid=%b status=%b want 1 0", done_valid, done_status); end
    checks++; if (job_start !== '0 || desc_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zm_idle: start=%b ready=%b busy=%b want 0000 1 0", job_start, desc_ready, busy);
    end
    step();
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL zm_pulse: done_valid=%b want 0", done_valid); end
    $display("job empty mask done");
  endtask

  task automatic test_reset_mid_fetch();
    begin_job(4'b0100, 32'hCAFE_0006);
    job_accept = 4'b0100;
    step();
    job_accept = '0; job_fetch_request = 4'b0100;
    step();
    checks++; if (fetch_valid !== 1'b1 || fetch_idx !== 2'd2) begin errors++; $display("FAIL rm_fetch: fv=%b idx=%0d want 1 2", fetch_valid, fetch_idx); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (fetch_valid !== 1'b0 || job_parameters !== '0 || busy !== 1'b0 || desc_ready !== 1'b0 || done_valid !== 1'b0) begin
      errors++; $display("FAIL rm_async: fv=%b params=%h busy=%b ready=%b done=%b want all 0", fetch_valid, job_parameters, busy, desc_ready, done_valid);
    end
    job_fetch_request = '0;
    step();
    step();
    rst = 1'b0;
    step();
    checks++; if (desc_ready !== 1'b1 || done_valid !== 1'b0) begin errors++; $display("FAIL rm_release: ready=%b done=%b want 1 0", desc_ready, done_valid); end
    $display("reset mid-fetch");
    begin_job(4'b1111, 32'hCAFE_0007);
    job_accept = 4'b1111;
    step();
    job_accept = '0; job_fetch_request = 4'b1111;
    step();
    checks++; if (job_fetch_ack !== 4'b0001 || fetch_idx !== 2'd0) begin errors++; $display("FAIL rm_ptr0: ack=%b idx=%0d want 0001 0", job_fetch_ack, fetch_idx); end
    fetch_done = 1'b1; job_fetch_request = '0;
    step();
    fetch_done = 1'b0;
    checks++; if (job_fetch_complete !== 4'b0001) begin errors++; $display("FAIL rm_complete: complete=%b want 0001", job_fetch_complete); end
    complete_job(4'b1111, 4'b1111);
  endtask

  initial begin
    rst = 1'b1; desc_valid = 1'b0; desc_params = '0; desc_quad_mask = '0;
    job_accept = '0; job_fetch_request = '0; fetch_done = 1'b0; job_complete = '0;
    test_reset();
    test_round_robin();
    test_complete_same_cycle();
    test_start_accept();
    test_timeout();
    test_zero_mask();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
